// File: rtl/gray_matrix_3x3.sv
// 3x3 luma window generator: two line buffers plus a two-stage registered pipeline.
// Emits one 9-pixel window per accepted pixel, with frame syncs delayed to match.
module gray_matrix_3x3 #(
  parameter int unsigned IMG_HDISP = 640
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_y,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [71:0] matrix_data
);

  localparam int unsigned AW   = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam logic [10:0] XMAX = 11'(IMG_HDISP - 1);

  logic          accept;
  logic [10:0]   x_q;
  logic [1:0]    y_q;
  logic [AW-1:0] addr;
  logic [1:0]    y_cur;
  logic          x_zero;

  assign accept = per_frame_href & per_frame_clken;
  // Outside the active frame the counters read as zero, even for a pixel accepted that cycle.
  assign addr   = per_frame_vsync ? x_q[AW-1:0] : '0;
  assign y_cur  = per_frame_vsync ? y_q : 2'd0;
  assign x_zero = !per_frame_vsync || (x_q == 11'd0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (!per_frame_vsync) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (x_q == XMAX) begin
        x_q <= '0;
        if (y_q != 2'd2) y_q <= y_q + 2'd1;
      end else begin
        x_q <= x_q + 11'd1;
      end
    end
  end

  // Line buffers: read-before-write on one address, no reset, so they map to block RAM.
  logic [7:0] lb1 [IMG_HDISP];
  logic [7:0] lb2 [IMG_HDISP];
  logic [7:0] lb1_rd;
  logic [7:0] lb2_rd;

  always_ff @(posedge sys_clk) begin
    if (accept && !sys_rst) begin
      lb1_rd    <= lb1[addr];
      lb2_rd    <= lb2[addr];
      lb2[addr] <= lb1[addr];
      lb1[addr] <= per_img_y;
    end
  end

  // Stage 1: current pixel and position alongside the line-buffer read.
  logic       s1_valid;
  logic [7:0] s1_pix;
  logic       s1_x0;
  logic [1:0] s1_y;
  logic       vs_d1;
  logic       hr_d1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_x0    <= 1'b0;
      s1_y     <= '0;
      vs_d1    <= 1'b0;
      hr_d1    <= 1'b0;
    end else begin
      s1_valid <= accept;
      vs_d1    <= per_frame_vsync;
      hr_d1    <= per_frame_href;
      if (accept) begin
        s1_pix <= per_img_y;
        s1_x0  <= x_zero;
        s1_y   <= y_cur;
      end
    end
  end

  // Rows not yet written in this frame are forced to zero to hide stale buffer data.
  logic [7:0] row1_new;
  logic [7:0] row2_new;

  assign row1_new = (s1_y == 2'd2) ? lb2_rd : 8'd0;
  assign row2_new = (s1_y != 2'd0) ? lb1_rd : 8'd0;

  // Stage 2: window shift registers and output syncs.
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
    end else begin
      post_frame_vsync <= vs_d1;
      post_frame_href  <= hr_d1;
      post_frame_clken <= s1_valid;
      if (s1_valid) begin
        if (s1_x0) begin
          // Zero left border; keeps the previous line's tail out of the window.
          p11 <= '0; p12 <= '0;
          p21 <= '0; p22 <= '0;
          p31 <= '0; p32 <= '0;
        end else begin
          p11 <= p12; p12 <= p13;
          p21 <= p22; p22 <= p23;
          p31 <= p32; p32 <= p33;
        end
        p13 <= row1_new;
        p23 <= row2_new;
        p33 <= s1_pix;
      end
    end
  end

  assign matrix_data = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

endmodule

// File: doc/gray_matrix_3x3.md
# gray_matrix_3x3

Generates a 3x3 neighbourhood window from the 8-bit luma stream produced by the RGB-to-YCbCr stage. It is the input stage for the 3x3 filters that follow it (Sobel, median, erosion/dilation). Two internal line buffers hold the previous image rows. For every valid input pixel, the block emits a registered 9-pixel window together with delayed frame sync signals.

## Interface
- IMG_HDISP, 640: active pixels per line; sets the line-buffer depth; legal range 3..2047.
- sys_clk  input  1  pixel clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- per_frame_vsync  input  1  input frame valid: high = active frame, low = vertical sync.
- per_frame_href  input  1  input line valid.
- per_frame_clken  input  1  input pixel strobe; a pixel is accepted only when href & clken.
- per_img_y  input  8  luma pixel, taken from the upstream gray_data[23:16].
- post_frame_vsync  output  1  per_frame_vsync delayed by 2 cycles.
- post_frame_href  output  1  per_frame_href delayed by 2 cycles.
- post_frame_clken  output  1  (href & clken) delayed by 2 cycles; marks a new window.
- matrix_data  output  72  window, packed row-major: p11 in [71:64], p12, p13, p21, p22, p23, p31, p32, p33 in [7:0]. Row 1 is the oldest row; column 3 is the newest pixel.

## Operation
- Accepted pixel: a cycle with per_frame_href & per_frame_clken high. All other input cycles are ignored; no state changes.
- Column counter x (11 bit):
  - increments on each accepted pixel;
  - wraps from IMG_HDISP-1 to 0;
  - cleared while per_frame_vsync is low.
- Row counter y (2 bit, saturating at 2):
  - increments when x wraps;
  - cleared while per_frame_vsync is low.
- Line buffers lb1 and lb2, each IMG_HDISP x 8. On an accepted pixel at column x:
  - read lb1[x] as row y-1 and lb2[x] as row y-2;
  - write lb2[x] <= lb1[x] and lb1[x] <= per_img_y.
  - Contents are never cleared. Stale data is hidden by the masking rules below.
- Stage 1 (registered):
  - capture the current pixel, lb1 read and lb2 read, plus the x and y values;
  - row masks: if y==0, force the lb1 and lb2 values to 0; if y==1, force the lb2 value to 0.
- Stage 2 (window shift), on a stage-1 valid:
  - each row shifts left: pr1<=pr2, pr2<=pr3, pr3<=new.
  - Row 1 takes the lb2 value, row 2 takes the lb1 value, row 3 takes the current pixel.
  - If the captured x==0, load pr1<=0 and pr2<=0 instead of shifting. This gives a zero left border and keeps the previous line's tail out of the window.
- Window content: for input pixel (x,y), p33=(x,y) and p22=(x-1,y-1). No end-of-line flush is performed; the rightmost column is never centred. This is accepted behaviour.
- Between valid windows, matrix_data holds its last value.
- sys_rst mid-frame:
  - clears x, y, both pipeline stages and all outputs;
  - the frame resumes with first-row masking, so stale line-buffer data is never visible.

## Timing
- Reset values: post_frame_vsync, post_frame_href, post_frame_clken and matrix_data are all 0.
- Latency is 2 cycles for all outputs. The window for the pixel accepted at cycle n is valid at cycle n+2, with post_frame_clken high in that cycle only.
- Throughput: one pixel per clock. Back-to-back clken is supported.
- Line-buffer read is synchronous: one read and one write of the same address per accepted pixel, read-before-write. The buffers must map to simple dual-port block RAM.
- vsync falling while a pixel is in the pipeline: the pipeline still drains, and the 2 in-flight windows are emitted unchanged.
- A pixel accepted in the same cycle that vsync is low still updates the line buffers, but uses x=0 and y=0.

## Test plan
- Reset: hold sys_rst 3 cycles with random inputs -> all outputs 0 throughout and 1 cycle after release.
- Ramp frame, IMG_HDISP=4, pixel=16*y+x, continuous clken -> input 0x22 yields 2 cycles later matrix_data = 00,01,02,10,11,12,20,21,22 with post_frame_clken=1.
- First-row masking -> input 0x01 at (1,0) yields 0,0,0,0,0,0,0,00,01.
- Left-edge reset -> input 0x20 at (0,2) yields 0,0,00,0,0,10,0,0,20.
- Sparse clken: every other cycle, repeating the ramp -> identical window sequence, post_frame_clken pulses exactly 2 cycles after each accepted pixel, matrix_data stable between pulses.
- Two frames with different ramps, vsync low between them -> the first windows of frame 2 show row masking (zeros), with no frame-1 values in rows 1-2.
